// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler
//
// Packs host bytes from the FX2 host-to-FPGA channel into big-endian frames
// of two 16-bit samples (A then B). Each frame is released to the DAC
// serializer on a programmable sample tick. Underruns are counted and a tick
// that lands while the previous pair is still unaccepted is flagged.
//
// Ports:
//   clk_in, reset          core clock, asynchronous active-low reset
//   chanAddr               currently selected FX2 channel
//   h2fData/h2fValid       host byte stream
//   h2fReady               byte accepted when high together with h2fValid
//   enable                 runs the sample tick (assembly continues while low)
//   period                 clock cycles per sample tick, 0 behaves as 1
//   smp_a/smp_b            sample pair to the serializer
//   smp_valid/smp_ready    handshake with the serializer
//   underrun_count         ticks with no complete frame, saturating
//   late                   sticky: tick arrived while smp_valid was pending
//   clr_status             synchronous clear of underrun_count and late
module dac_sample_scheduler #(
    parameter logic [6:0] CHAN_ADDR = 7'd0,
    parameter int         PERIOD_W  = 16,
    parameter int         CNT_W     = 16
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [6:0]          chanAddr,
    input  logic [7:0]          h2fData,
    input  logic                h2fValid,
    output logic                h2fReady,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic [15:0]         smp_a,
    output logic [15:0]         smp_b,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic [CNT_W-1:0]    underrun_count,
    output logic                late,
    input  logic                clr_status
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    logic [1:0]          idx_q, idx_d;
    logic [31:0]         asm_q, asm_d;
    logic                frame_full_q, frame_full_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                tick_q, tick_d;
    state_t              state_q, state_d;
    logic [15:0]         smp_a_q, smp_a_d;
    logic [15:0]         smp_b_q, smp_b_d;
    logic [CNT_W-1:0]    underrun_q, underrun_d;
    logic                late_q, late_d;

    logic                byte_accept;
    logic                frame_take;
    logic [PERIOD_W-1:0] last_cnt;

    assign h2fReady    = (chanAddr == CHAN_ADDR) && !frame_full_q;
    assign byte_accept = h2fValid && h2fReady;
    // A frame is consumed only by a tick seen in IDLE; h2fReady is low while
    // frame_full is set, so consume and the 4th-byte set never coincide.
    assign frame_take  = (state_q == ST_IDLE) && tick_q && frame_full_q;
    // period == 0 behaves as period == 1 (tick every cycle).
    assign last_cnt    = (period == '0) ? '0 : period - PERIOD_W'(1);

    // Byte assembler: big-endian A[15:8], A[7:0], B[15:8], B[7:0].
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        idx_d        = idx_q;
        asm_d        = asm_q;
        frame_full_d = frame_full_q;
        if (byte_accept) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    asm_d[31:24] = h2fData;
                2'd1:    asm_d[23:16] = h2fData;
                2'd2:    asm_d[15:8]  = h2fData;
                default: asm_d[7:0]   = h2fData;
            endcase
            if (idx_q == 2'd3) begin
                frame_full_d = 1'b1;
            end
        end
        if (frame_take) begin
            frame_full_d = 1'b0;
        end
    end

    // Tick counter. The compare is against the live period, so a period
    // lowered below cnt lets the counter run on and wrap at its maximum.
    // The tick is registered: the FSM acts on it one edge after the wrap.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == last_cnt) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    // Output FSM: IDLE waits for a tick, PEND offers the pair until accepted.
    always_comb begin
        state_d    = state_q;
        smp_a_d    = smp_a_q;
        smp_b_d    = smp_b_q;
        underrun_d = underrun_q;
        late_d     = late_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_q) begin
                    state_d = ST_PEND;
                    if (frame_full_q) begin
                        smp_a_d = asm_q[31:16];
                        smp_b_d = asm_q[15:0];
                    end else if (underrun_q != '1) begin
                        // Underrun: previous pair is re-offered unchanged.
                        underrun_d = underrun_q + CNT_W'(1);
                    end
                end
            end
            ST_PEND: begin
                // A tick here is dropped: nothing consumed, nothing counted.
                if (tick_q) begin
                    late_d = 1'b1;
                end
                if (smp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Clear has priority over a same-cycle underrun increment.
        if (clr_status) begin
            underrun_d = '0;
            late_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            // NOTE: the assembly and sample registers are reset too; smp_a/b
            // are visible outputs with defined reset values, and the partial
            // frame must not leak into a later frame.
            idx_q        <= 2'd0;
            asm_q        <= '0;
            frame_full_q <= 1'b0;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            state_q      <= ST_IDLE;
            smp_a_q      <= '0;
            smp_b_q      <= '0;
            underrun_q   <= '0;
            late_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples the
            // pre-edge values computed above regardless of statement order.
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            frame_full_q <= frame_full_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            state_q      <= state_d;
            smp_a_q      <= smp_a_d;
            smp_b_q      <= smp_b_d;
            underrun_q   <= underrun_d;
            late_q       <= late_d;
        end
    end

    assign smp_a          = smp_a_q;
    assign smp_b          = smp_b_q;
    assign smp_valid      = (state_q == ST_PEND);
    assign underrun_count = underrun_q;
    assign late           = late_q;

endmodule
